// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM, op/funct to ALU code, branch PC enable.
// Optional bne support when MC_CONTROLLER_BNE_EN is defined; MEM_WAIT stretches FETCH/MEMRD/MEMWR.
module mc_controller #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alucontrol,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg
);

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BNE  = 6'b000101;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
      BEQEX, ADDIEX, ADDIWB, JEX, BNEEX
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       last;
   logic       is_sw;
   logic       pcwrite, branch;
   logic [2:0] fdec;
   logic       fok;
`ifdef MC_CONTROLLER_BNE_EN
   logic       branchne;
`endif

   assign last = (cnt == 4'(MEM_WAIT));

   // op is only valid in DECODE, so the lw/sw choice is kept for MEMADR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         cnt   <= 4'd0;
         is_sw <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
         if (state == DECODE)
            is_sw <= (op == OP_SW);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (last) state_nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_R:         state_nxt = RTYPEEX;
               OP_BEQ:       state_nxt = BEQEX;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_J:         state_nxt = JEX;
`ifdef MC_CONTROLLER_BNE_EN
               OP_BNE:       state_nxt = BNEEX;
`endif
               default:      state_nxt = FETCH;
            endcase
         end
         MEMADR:  state_nxt = is_sw ? MEMWR : MEMRD;
         MEMRD:   if (last) state_nxt = MEMWB;
         MEMWR:   if (last) state_nxt = FETCH;
         RTYPEEX: state_nxt = RTYPEWB;
         ADDIEX:  state_nxt = ADDIWB;
         default: state_nxt = FETCH;
      endcase
   end

   always_comb begin
      fdec = 3'b010;
      fok  = 1'b1;
      case (funct)
         6'b100000: fdec = 3'b010;
         6'b100010: fdec = 3'b110;
         6'b100100: fdec = 3'b000;
         6'b100101: fdec = 3'b001;
         6'b101010: fdec = 3'b111;
         default:   fok  = 1'b0;
      endcase
   end

   // strobes fire only on the last cycle of a wait-stretched state
   always_comb begin
      alucontrol = 3'b010;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
`ifdef MC_CONTROLLER_BNE_EN
      branchne   = 1'b0;
`endif
      case (state)
         FETCH: begin
            alusrcb = 2'b01;
            irwrite = last;
            pcwrite = last;
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = last;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = fdec;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = fok;
         end
         BEQEX: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branch     = 1'b1;
         end
`ifdef MC_CONTROLLER_BNE_EN
         BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branchne   = 1'b1;
         end
`endif
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB:  regwrite = 1'b1;
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MC_CONTROLLER_BNE_EN
   assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);
`else
   assign pcen = pcwrite | (branch & zero);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: two instances (MEM_WAIT 0 and 3) against a per-instruction step model.
// Honours MC_CONTROLLER_BNE_EN the same way the design does.
module tb_mc_controller;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam logic [5:0] BNE = 6'b000101, BAD = 6'b111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a  [2] = '{1'b1, 1'b1};
   logic [5:0] op_a   [2] = '{6'd0, 6'd0};
   logic [5:0] fn_a   [2] = '{6'd0, 6'd0};
   logic       zero_a [2] = '{1'b0, 1'b0};
   logic [2:0] alc    [2];
   logic       sa     [2];
   logic [1:0] sb     [2];
   logic [1:0] ps     [2];
   logic       pcen   [2];
   logic       iord   [2];
   logic       mw     [2];
   logic       irw    [2];
   logic       rw     [2];
   logic       rd     [2];
   logic       m2r    [2];

   mc_controller #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .reset(rst_a[0]), .op(op_a[0]), .funct(fn_a[0]), .zero(zero_a[0]),
      .alucontrol(alc[0]), .alusrca(sa[0]), .alusrcb(sb[0]), .pcsrc(ps[0]), .pcen(pcen[0]),
      .iord(iord[0]), .memwrite(mw[0]), .irwrite(irw[0]), .regwrite(rw[0]),
      .regdst(rd[0]), .memtoreg(m2r[0]));

   mc_controller #(.MEM_WAIT(3)) dut1 (
      .clk(clk), .reset(rst_a[1]), .op(op_a[1]), .funct(fn_a[1]), .zero(zero_a[1]),
      .alucontrol(alc[1]), .alusrca(sa[1]), .alusrcb(sb[1]), .pcsrc(ps[1]), .pcen(pcen[1]),
      .iord(iord[1]), .memwrite(mw[1]), .irwrite(irw[1]), .regwrite(rw[1]),
      .regdst(rd[1]), .memtoreg(m2r[1]));

   int nvec = 0;
   int nfail = 0;
   logic [14:0] exp_v [2];
   bit          exp_ok [2] = '{1'b0, 1'b0};
   bit          aborted [2];
   int          abort_at [2] = '{-1, -1};
   int          kstep [2];
   int          cyc [2] = '{0, 0};
   int          last_irw [2] = '{0, 0};
   int          last_int [2] = '{0, 0};
   int          irw_cnt [2] = '{0, 0};
   int          mw_cnt [2] = '{0, 0};

   function automatic int mwait(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic [14:0] pack(input logic [2:0] a, input logic s_a, input logic [1:0] s_b,
                                         input logic [1:0] p_s, input logic p_e, input logic i_o,
                                         input logic m_w, input logic i_r, input logic r_w,
                                         input logic r_d, input logic m_r);
      return {a, s_a, s_b, p_s, p_e, i_o, m_w, i_r, r_w, r_d, m_r};
   endfunction

   function automatic logic [14:0] actual(input int d);
      return pack(alc[d], sa[d], sb[d], ps[d], pcen[d], iord[d], mw[d], irw[d], rw[d], rd[d], m2r[d]);
   endfunction

   function automatic logic [2:0] fdec(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic logic fvalid(input logic [5:0] f);
      return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
             (f == 6'b100101) || (f == 6'b101010);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (exp_ok[d]) begin
            nvec++;
            if (actual(d) !== exp_v[d]) begin
               nfail++;
               $display("FAIL dut%0d outputs at cycle %0d: got %b want %b", d, cyc[d], actual(d), exp_v[d]);
            end
         end
         if (irw[d] === 1'b1) begin
            last_int[d] = cyc[d] - last_irw[d];
            last_irw[d] = cyc[d];
            irw_cnt[d]++;
         end
         if (mw[d] === 1'b1) mw_cnt[d]++;
         cyc[d]++;
      end
   end

   // One cycle of one instance: drive inputs, set the expected Moore outputs, advance.
   // br: 0 no branch, 1 branch on zero, 2 branch on not-zero.
   task automatic step(input int d, input bit rst, input bit hold, input logic [5:0] o, input logic [5:0] f,
                       input logic [2:0] a, input logic s_a, input logic [1:0] s_b, input logic [1:0] p_s,
                       input bit pw, input int br, input logic i_o, input logic m_w, input logic i_r,
                       input logic r_w, input logic r_d, input logic m_r);
      logic z;
      logic pe;
      z = 1'($urandom_range(0, 1));
      if (aborted[d]) return;
      if (kstep[d] == abort_at[d]) begin
         rst = 1'b1;
         aborted[d] = 1'b1;
      end
      kstep[d]++;
      rst_a[d]  = rst;
      zero_a[d] = z;
      op_a[d]   = hold ? o : 6'($urandom);
      fn_a[d]   = hold ? f : 6'($urandom);
      if (rst) begin
         pe = (mwait(d) == 0);
         exp_v[d] = pack(3'b010, 1'b0, 2'b01, 2'b00, pe, 1'b0, 1'b0, pe, 1'b0, 1'b0, 1'b0);
      end else begin
         pe = pw | ((br == 1) & z) | ((br == 2) & ~z);
         exp_v[d] = pack(a, s_a, s_b, p_s, pe, i_o, m_w, i_r, r_w, r_d, m_r);
      end
      exp_ok[d] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f);
      int w;
      w = mwait(d);
      aborted[d] = 1'b0;
      kstep[d] = 0;
      for (int i = 0; i <= w; i++)
         step(d, 0, 0, o, f, 3'b010, 0, 2'b01, 2'b00, (i == w), 0, 0, 0, (i == w), 0, 0, 0);
      step(d, 0, 1, o, f, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      case (o)
         LW, SW: begin
            step(d, 0, 0, o, f, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i <= w; i++)
               step(d, 0, 0, o, f, 3'b010, 0, 2'b00, 2'b00, 0, 0, 1, (o == SW && i == w), 0, 0, 0, 0);
            if (o == LW)
               step(d, 0, 0, o, f, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1);
         end
         RT: begin
            step(d, 0, 1, o, f, fdec(f), 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            step(d, 0, 1, o, f, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, fvalid(f), 1, 0);
         end
         BEQ: step(d, 0, 0, o, f, 3'b110, 1, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef MC_CONTROLLER_BNE_EN
         BNE: step(d, 0, 0, o, f, 3'b110, 1, 2'b00, 2'b01, 0, 2, 0, 0, 0, 0, 0, 0);
`endif
         ADDI: begin
            step(d, 0, 0, o, f, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            step(d, 0, 0, o, f, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
         end
         JMP: step(d, 0, 0, o, f, 3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
         default: ;
      endcase
   endtask

   task automatic run_dut(input int d);
      logic [5:0] dops [9];
      int         lens [8];
      int         i0, m0;
      logic [5:0] o, f;
      dops = '{RT, LW, SW, BEQ, ADDI, JMP, BAD, BNE, BAD};
`ifdef MC_CONTROLLER_BNE_EN
      if (d == 0) lens = '{4, 5, 4, 3, 4, 3, 2, 3};
      else        lens = '{7, 11, 10, 6, 7, 6, 5, 6};
`else
      if (d == 0) lens = '{4, 5, 4, 3, 4, 3, 2, 2};
      else        lens = '{7, 11, 10, 6, 7, 6, 5, 5};
`endif
      for (int i = 0; i < 3; i++)
         step(d, 1, 0, 6'd0, 6'd0, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 9; i++) begin
         i0 = irw_cnt[d];
         m0 = mw_cnt[d];
         run_instr(d, dops[i], 6'b100010);
         chk($sformatf("dut%0d instr%0d irwrite pulses", d, i), irw_cnt[d] - i0, 1);
         if (dops[i] == SW)
            chk($sformatf("dut%0d sw memwrite pulses", d), mw_cnt[d] - m0, 1);
         if (i > 0)
            chk($sformatf("dut%0d instr%0d length", d, i - 1), last_int[d], lens[i - 1]);
      end

      // reset in the middle of MEMWR: no memwrite strobe may escape
      m0 = mw_cnt[d];
      abort_at[d] = (d == 0) ? 3 : 7;
      run_instr(d, SW, 6'd0);
      abort_at[d] = -1;
      run_instr(d, BAD, 6'd0);
      chk($sformatf("dut%0d aborted sw memwrite pulses", d), mw_cnt[d] - m0, 0);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0, 9:    o = LW;
            1:       o = SW;
            2, 3:    o = RT;
            4:       o = BEQ;
            5:       o = ADDI;
            6:       o = JMP;
            7:       o = BNE;
            default: o = 6'($urandom);
         endcase
         case ($urandom_range(0, 6))
            0:       f = 6'b100000;
            1:       f = 6'b100010;
            2:       f = 6'b100100;
            3:       f = 6'b100101;
            4:       f = 6'b101010;
            default: f = 6'($urandom);
         endcase
         if ($urandom_range(0, 11) == 0) abort_at[d] = $urandom_range(0, 9);
         run_instr(d, o, f);
         abort_at[d] = -1;
      end
      exp_ok[d] = 1'b0;
   endtask

   initial begin
      fork
         run_dut(0);
         run_dut(1);
      join
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
